vga_scan_timing: RTL

Pixel-timing generator sitting directly upstream of the frame renderer. Free-running horizontal/vertical counters produce the scan coordinate (`x`, `y`), the active-area flag `o_active`, and the monitor sync pulses. Sync outputs are delayed to line up with the renderer's registered colour output. Also produces frame-level strobes used by game logic to update paddle, ball and brick state outside the visible area.

---
 rtl/vga_scan_timing.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// -----------------------------------------------------------------------------
// vga_scan_timing
//
// Pixel-timing generator for the frame renderer. Free-running horizontal and
// vertical counters produce the scan coordinate, the active-area flag, the
// monitor sync pulses and two frame-level strobes used by game logic.
//
// The sync pulses are delayed by SYNC_DELAY enabled cycles so that they line
// up with the renderer's registered colour output.
//
// Optional feature macro: VGA_SCAN_PATTERN_EN
//   When defined, a registered eight-bar colour test pattern is produced on
//   pattern_rgb. When not defined, the port and its logic are absent.
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous reset, active low
//   ce           in   pixel enable; counters, syncs and delay stages advance
//                     only when high
//   x            out  horizontal count, 0..H_TOTAL-1
//   y            out  vertical count, 0..V_TOTAL-1
//   o_active     out  (x,y) lies inside the visible area
//   hsync        out  delayed horizontal sync, polarity from SYNC_POL
//   vsync        out  delayed vertical sync, polarity from SYNC_POL
//   frame_start  out  one-pixel strobe at (0,0)
//   vblank_start out  one-pixel strobe at (0,V_ACTIVE)
//   pattern_rgb  out  3:3:3 test pattern (VGA_SCAN_PATTERN_EN only)
// -----------------------------------------------------------------------------
module vga_scan_timing #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BP       = 64,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 23,
  parameter bit SYNC_POL   = 1'b1,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        o_active,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        vblank_start
`ifdef VGA_SCAN_PATTERN_EN
  ,
  output logic [8:0]  pattern_rgb
`endif
);

  localparam logic [10:0] H_TOTAL_M1 = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0]  V_TOTAL_M1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        r_running;
  logic [10:0] r_x;
  logic [9:0]  r_y;

  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_hs_dly;
  logic w_vs_dly;

  // running goes high on the first edge after reset release regardless of ce,
  // so (0,0) is presented for one full cycle before the counters move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_running <= 1'b1;
      if (r_running && ce) begin
        if (r_x == H_TOTAL_M1) begin
          r_x <= '0;
          r_y <= (r_y == V_TOTAL_M1) ? '0 : r_y + 10'd1;
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  assign w_active = r_running && (r_x < H_ACT) && (r_y < V_ACT);
  assign w_hs_raw = (r_x >= H_SYNC_ON) && (r_x < H_SYNC_OFF);
  assign w_vs_raw = (r_y >= V_SYNC_ON) && (r_y < V_SYNC_OFF);

  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign w_hs_dly = w_hs_raw;
      assign w_vs_dly = w_vs_raw;
    end else begin : g_sync_pipe
      logic [SYNC_DELAY-1:0] r_hs_pipe;
      logic [SYNC_DELAY-1:0] r_vs_pipe;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_hs_pipe <= '0;
          r_vs_pipe <= '0;
        end else if (ce) begin
          r_hs_pipe[0] <= w_hs_raw;
          r_vs_pipe[0] <= w_vs_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
          end
        end
      end

      assign w_hs_dly = r_hs_pipe[SYNC_DELAY-1];
      assign w_vs_dly = r_vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign x            = r_x;
  assign y            = r_y;
  assign o_active     = w_active;
  assign hsync        = SYNC_POL ? w_hs_dly : ~w_hs_dly;
  assign vsync        = SYNC_POL ? w_vs_dly : ~w_vs_dly;
  assign frame_start  = r_running && ce && (r_x == '0) && (r_y == '0);
  assign vblank_start = r_running && ce && (r_x == '0) && (r_y == V_ACT);

`ifdef VGA_SCAN_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [2:0] w_bar;
  logic [8:0] r_pattern;

  // Only the low three bits matter: the index is 0..7 inside the active area,
  // and the result is forced to zero outside it.
  assign w_bar = 3'(r_x / BAR_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pattern <= '0;
    end else if (ce) begin
      r_pattern <= w_active ? {{3{w_bar[2]}}, {3{w_bar[1]}}, {3{w_bar[0]}}} : 9'd0;
    end
  end

  assign pattern_rgb = r_pattern;
`endif

endmodule
